// File: rtl/lattice_result_arbiter.sv
// rtl/lattice_result_arbiter.sv - round-robin arbiter returning the winning lattice core index
// Optional build macro LATTICE_ARB_STOP_EN: halt the search after the first transferred result.
module lattice_result_arbiter #(
    parameter int NCORES  = 4,
    parameter int IDXBITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               block_start,
    input  logic [NCORES-1:0]  core_valid,
    input  logic [NCORES-1:0]  core_success,
    input  logic               result_ready,
    output logic               result_valid,
    output logic [IDXBITS-1:0] result_index,
    output logic [7:0]         result_count,
    output logic               dropped,
    output logic               stopped
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NCORES-1:0]   pending;
    logic [NCORES-1:0]   pending_nxt;
    logic [NCORES-1:0]   succ;
    logic [NCORES-1:0]   clr;
    logic [IDXBITS-1:0]  last_grant;
    logic [IDXBITS-1:0]  pick;
    logic                pick_found;
    logic                xfer;
    logic                drop_evt;
    logic                halted;

`ifdef LATTICE_ARB_STOP_EN
    logic stop_r;
    assign halted  = stop_r;
    assign stopped = stop_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stop_r <= 1'b0;
        else if (block_start)
            stop_r <= 1'b0;
        else if (xfer)
            stop_r <= 1'b1;
    end
`else
    assign halted  = 1'b0;
    assign stopped = 1'b0;
`endif

    assign result_valid = (state == GRANT);
    assign xfer         = (state == GRANT) && result_ready;
    assign succ         = core_valid & core_success & {NCORES{~halted}};
    assign clr          = xfer ? (NCORES'(1) << result_index) : '0;
    assign pending_nxt  = (pending & ~clr) | succ;
    // A repeat success for the core being transferred this cycle is simply re-armed, not lost
    assign drop_evt     = |(succ & pending & ~clr);

    // First pending core after the last grant, wrapping at NCORES-1
    always_comb begin : rr_pick
        int                 j;
        logic [IDXBITS-1:0] jj;
        j          = 0;
        jj         = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            j  = (int'(last_grant) + k) % NCORES;
            jj = IDXBITS'(j);
            if (!pick_found && pending[jj]) begin
                pick_found = 1'b1;
                pick       = jj;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found && !halted) state_nxt = GRANT;
            GRANT:   if (result_ready)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            last_grant   <= IDXBITS'(NCORES - 1);
            result_index <= '0;
            result_count <= 8'd0;
            dropped      <= 1'b0;
        end else if (block_start) begin
            state        <= IDLE;
            pending      <= '0;
            result_count <= 8'd0;
            dropped      <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (drop_evt)
                dropped <= 1'b1;
            if (state == IDLE && state_nxt == GRANT)
                result_index <= pick;
            if (xfer) begin
                last_grant <= result_index;
                if (result_count != 8'hFF)
                    result_count <= result_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lattice_result_arbiter.sv
// tb/tb_lattice_result_arbiter.sv - randomized and directed bench for lattice_result_arbiter
module tb_lattice_result_arbiter;

    localparam int N  = 4;
    localparam int IB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          block_start;
    logic [N-1:0]  core_valid;
    logic [N-1:0]  core_success;
    logic          result_ready;
    logic          result_valid;
    logic [IB-1:0] result_index;
    logic [7:0]    result_count;
    logic          dropped;
    logic          stopped;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_pend [N];
    bit m_gr;
    bit m_drop;
    bit m_stop;
    int m_idx;
    int m_last;
    int m_cnt;
    int xfers [$];

    always #5 clk = ~clk;

    lattice_result_arbiter #(.NCORES(N), .IDXBITS(IB)) dut (
        .clk          (clk),
        .rst          (rst),
        .block_start  (block_start),
        .core_valid   (core_valid),
        .core_success (core_success),
        .result_ready (result_ready),
        .result_valid (result_valid),
        .result_index (result_index),
        .result_count (result_count),
        .dropped      (dropped),
        .stopped      (stopped)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_gr = 0; m_drop = 0; m_stop = 0;
        m_idx = 0; m_last = N - 1; m_cnt = 0;
    endtask

    task automatic model_step(input bit bs, input logic [N-1:0] v, input logic [N-1:0] s, input bit rdy);
        bit np [N];
        bit xf;
        if (bs) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_gr = 0; m_drop = 0; m_stop = 0; m_cnt = 0;
            return;
        end
        xf = m_gr && rdy;
        for (int i = 0; i < N; i++) begin
            bit sc;
            bit cl;
            sc = v[i] && s[i] && !m_stop;
            cl = xf && (m_idx == i);
            if (sc && m_pend[i] && !cl) m_drop = 1;
            np[i] = (m_pend[i] && !cl) || sc;
        end
        if (xf) begin
            m_last = m_idx;
            if (m_cnt < 255) m_cnt++;
            m_gr = 0;
`ifdef LATTICE_ARB_STOP_EN
            m_stop = 1;
`endif
        end else if (!m_gr && !m_stop) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (!m_gr && m_pend[j]) begin
                    m_idx = j;
                    m_gr  = 1;
                end
            end
        end
        for (int i = 0; i < N; i++) m_pend[i] = np[i];
    endtask

    task automatic compare_outputs();
        check("valid", result_valid, m_gr);
        if (m_gr) check("index", result_index, m_idx);
        check("count", result_count, m_cnt);
        check("dropped", dropped, m_drop);
        check("stopped", stopped, m_stop);
    endtask

    task automatic cycle(input bit bs, input logic [N-1:0] v, input logic [N-1:0] s, input bit rdy);
        block_start  = bs;
        core_valid   = v;
        core_success = s;
        result_ready = rdy;
        if (result_valid && rdy && !bs) xfers.push_back(int'(result_index));
        @(posedge clk);
        model_step(bs, v, s, rdy);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        block_start = 0; core_valid = '0; core_success = '0; result_ready = 0;
        rst = 1'b1;
        #2;
        model_reset();
        check("rst_valid", result_valid, 0);
        check("rst_index", result_index, 0);
        check("rst_count", result_count, 0);
        check("rst_dropped", dropped, 0);
        check("rst_stopped", stopped, 0);
        @(negedge clk);
        rst = 1'b0;
        xfers.delete();
    endtask

    initial begin
        do_reset();

        // single success on core 2
        idle(4, 1'b1);
        cycle(1'b0, 4'b0100, 4'b0100, 1'b1);
        check("s1_latency", result_valid, 0);
        cycle(1'b0, '0, '0, 1'b1);
        check("s1_valid", result_valid, 1);
        check("s1_index", result_index, 2);
        idle(3, 1'b1);
        check("s1_count", result_count, 1);
        check("s1_nxfer", xfers.size(), 1);

        // valid without success is ignored
        cycle(1'b0, 4'b0010, 4'b0000, 1'b1);
        idle(3, 1'b1);
        check("nosucc_nxfer", xfers.size(), 1);

        // round robin from reset
        do_reset();
        cycle(1'b0, 4'b1011, 4'b1011, 1'b1);
        idle(8, 1'b1);
        check("rr_n", xfers.size(), 3);
        if (xfers.size() == 3) begin
            check("rr_0", xfers[0], 0);
            check("rr_1", xfers[1], 1);
            check("rr_2", xfers[2], 3);
        end
        check("rr_count", result_count, 3);
        xfers.delete();
        cycle(1'b0, 4'b0011, 4'b0011, 1'b1);
        idle(6, 1'b1);
        check("rr2_n", xfers.size(), 2);
        if (xfers.size() == 2) begin
            check("rr2_0", xfers[0], 0);
            check("rr2_1", xfers[1], 1);
        end

        // backpressure and drop
        do_reset();
        cycle(1'b0, 4'b0010, 4'b0010, 1'b0);
        idle(4, 1'b0);
        cycle(1'b0, 4'b0010, 4'b0010, 1'b0);
        idle(5, 1'b0);
        check("bp_valid", result_valid, 1);
        check("bp_index", result_index, 1);
        check("bp_dropped", dropped, 1);
        idle(4, 1'b1);
        check("bp_nxfer", xfers.size(), 1);

        // block_start collides with a success while granting core 0
        do_reset();
        cycle(1'b0, 4'b0001, 4'b0001, 1'b0);
        idle(1, 1'b0);
        check("bs_pre_valid", result_valid, 1);
        cycle(1'b1, 4'b1000, 4'b1000, 1'b0);
        check("bs_valid", result_valid, 0);
        check("bs_count", result_count, 0);
        idle(5, 1'b1);
        check("bs_nxfer", xfers.size(), 0);

        // stop mode behaviour (or continuous arbitration without it)
        do_reset();
        cycle(1'b0, 4'b0101, 4'b0101, 1'b1);
        idle(6, 1'b1);
`ifdef LATTICE_ARB_STOP_EN
        check("stop_n", xfers.size(), 1);
        check("stop_flag", stopped, 1);
`else
        check("stop_n", xfers.size(), 2);
        check("stop_flag", stopped, 0);
`endif
        if (xfers.size() > 0) check("stop_first", xfers[0], 0);

        // async reset while granting
        do_reset();
        cycle(1'b0, 4'b0100, 4'b0100, 1'b0);
        idle(1, 1'b0);
        check("ar_pre_valid", result_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("ar_valid", result_valid, 0);
        check("ar_index", result_index, 0);
        check("ar_count", result_count, 0);
        check("ar_dropped", dropped, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(4, 1'b1);

        // saturating counter
        do_reset();
        for (int i = 0; i < 700; i++) cycle(1'b0, 4'b1111, 4'b1111, 1'b1);
`ifdef LATTICE_ARB_STOP_EN
        check("sat_count", result_count, 1);
`else
        check("sat_count", result_count, 255);
`endif

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] v;
            logic [N-1:0] s;
            v = N'($urandom & $urandom);
            s = N'($urandom);
            cycle(($urandom % 64) == 0, v, s, ($urandom % 4) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
